movsum_sequencer: RTL and testbench

- Controller that sequences one shared moving-sum (bounded integrator) datapath: y[n] = x[n] + y[n-1] - x[n-WIN].
- Owns the integrator's clear, input handshake and output-ready, so the integrator's combinational valid/ready never escape.
- Suppresses warm-up outputs until the window is full, decimates results by a runtime factor, and buffers one result against downstream backpressure.
- Sits between the sample stream and the DSP consumer in the receive chain.

---
 rtl/movsum_sequencer_pkg.sv | 30 +++
 rtl/movsum_out_reg.sv | 35 +++
 rtl/movsum_sequencer.sv | 143 ++++++++++++++
 tb/tb_movsum_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/movsum_sequencer_pkg.sv
// Shared definitions for the moving-sum sequencer: FSM state encoding,
// width helpers and default widths.
package movsum_sequencer_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StFlush = 2'd1;
  localparam state_t StFill  = 2'd2;
  localparam state_t StRun   = 2'd3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefWin   = 5;
  localparam int unsigned DefDecW  = 8;
  localparam int unsigned DefSumW  = DefWidth + clog2(DefWin + 1);

endpackage

// File: rtl/movsum_out_reg.sv
// One-entry output holding register with valid/ready. The parent only loads
// when the entry is empty or draining this cycle.
module movsum_out_reg #(
  parameter int unsigned W = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Hold data while stalled; flush drops the entry and zeroes the data.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/movsum_sequencer.sv
// Sequencer for a shared moving-sum integrator: owns clear, input handshake
// and output-ready, hides warm-up results, decimates and buffers one result.
// Optional statistics counters are built when MOVSUM_SEQ_STATS_EN is defined.
module movsum_sequencer
  import movsum_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned WIN   = DefWin,
  parameter int unsigned SUM_W = WIDTH + clog2(WIN + 1),
  parameter int unsigned DEC_W = DefDecW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_enable,
  input  logic             cfg_restart,
  input  logic [DEC_W-1:0] cfg_decim,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic             ig_clear,
  output logic [WIDTH-1:0] ig_tdata,
  output logic             ig_tvalid,
  output logic             ig_oready,
  input  logic [SUM_W-1:0] ig_sum,
  output logic [SUM_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
`ifdef MOVSUM_SEQ_STATS_EN
  ,
  output logic [31:0]      stat_emitted,
  output logic [31:0]      stat_stall
`endif
);

  localparam int unsigned FillW = cnt_w(WIN);

  state_t             state_q, state_d;
  logic [FillW-1:0]   fill_cnt_q;
  logic [DEC_W-1:0]   dec_cnt_q, dec_q;
  logic               cap_pend_q;

  logic active, at_fill_end, candidate, emit, discard;
  logic out_blocked, pend_blocked, accept, abort, load;

  assign active       = (state_q == StFill) || (state_q == StRun);
  assign at_fill_end  = (state_q == StFill) && (fill_cnt_q == FillW'(WIN - 1));
  assign candidate    = (state_q == StRun) || at_fill_end;
  assign emit         = candidate && (dec_cnt_q == '0);
  assign discard      = active && !emit;
  assign out_blocked  = m_tvalid && !m_tready;
  // A pending capture that cannot drain must keep ig_sum frozen.
  assign pend_blocked = cap_pend_q && out_blocked;
  assign s_tready     = discard || (active && !pend_blocked && !out_blocked);
  assign accept       = s_tvalid && s_tready;
  assign abort        = active && (!cfg_enable || cfg_restart);
  // ig_sum updated on the accept edge; capture it one edge later.
  assign load         = cap_pend_q && !out_blocked && !abort;

  assign ig_clear  = (state_q == StIdle) || (state_q == StFlush);
  assign ig_tdata  = s_tdata;
  assign ig_tvalid = accept;
  assign ig_oready = s_tready;

  // Next-state logic; disable takes priority over restart.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_enable) state_d = StFlush;
      StFlush: state_d = StFill;
      StFill: begin
        if (abort)                       state_d = cfg_enable ? StFlush : StIdle;
        else if (accept && at_fill_end)  state_d = StRun;
      end
      StRun:   if (abort) state_d = cfg_enable ? StFlush : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, fill/decimation counters and the pending-capture flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fill_cnt_q <= '0;
      dec_cnt_q  <= '0;
      dec_q      <= DEC_W'(1);
      cap_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StFlush) begin
        fill_cnt_q <= '0;
        dec_cnt_q  <= '0;
        dec_q      <= (cfg_decim == '0) ? DEC_W'(1) : cfg_decim;
        cap_pend_q <= 1'b0;
      end else if (!active || abort) begin
        cap_pend_q <= 1'b0;
      end else begin
        if (accept && (state_q == StFill) && !at_fill_end) begin
          fill_cnt_q <= fill_cnt_q + FillW'(1);
        end
        if (accept && candidate) begin
          dec_cnt_q <= (dec_cnt_q == dec_q - DEC_W'(1)) ? '0 : dec_cnt_q + DEC_W'(1);
        end
        cap_pend_q <= (accept && emit) || pend_blocked;
      end
    end
  end

  movsum_out_reg #(
    .W (SUM_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .load      (load),
    .load_data (ig_sum),
    .ready     (m_tready),
    .valid     (m_tvalid),
    .data      (m_tdata)
  );

`ifdef MOVSUM_SEQ_STATS_EN
  logic [31:0] stat_emitted_q, stat_stall_q;

  // Saturating statistics counters, cleared by reset and FLUSH.
  always_ff @(posedge clk) begin
    if (reset || (state_q == StFlush)) begin
      stat_emitted_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      if (m_tvalid && m_tready && (stat_emitted_q != '1)) begin
        stat_emitted_q <= stat_emitted_q + 32'd1;
      end
      if (active && s_tvalid && !s_tready && (stat_stall_q != '1)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_emitted = stat_emitted_q;
  assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_movsum_sequencer.sv
// Self-checking bench for movsum_sequencer with a behavioural moving-sum
// integrator standing in for the shared datapath.
module tb_movsum_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned WIN   = 5;
  localparam int unsigned SUM_W = 19;
  localparam int unsigned DEC_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_enable, cfg_restart;
  logic [DEC_W-1:0] cfg_decim;
  logic [WIDTH-1:0] s_tdata;
  logic             s_tvalid, s_tready;
  logic             ig_clear, ig_tvalid, ig_oready;
  logic [WIDTH-1:0] ig_tdata;
  logic [SUM_W-1:0] ig_sum;
  logic [SUM_W-1:0] m_tdata;
  logic             m_tvalid, m_tready;
`ifdef MOVSUM_SEQ_STATS_EN
  logic [31:0]      stat_emitted, stat_stall;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  movsum_sequencer #(
    .WIDTH (WIDTH),
    .WIN   (WIN),
    .SUM_W (SUM_W),
    .DEC_W (DEC_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_enable  (cfg_enable),
    .cfg_restart (cfg_restart),
    .cfg_decim   (cfg_decim),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .ig_clear    (ig_clear),
    .ig_tdata    (ig_tdata),
    .ig_tvalid   (ig_tvalid),
    .ig_oready   (ig_oready),
    .ig_sum      (ig_sum),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready)
`ifdef MOVSUM_SEQ_STATS_EN
    ,
    .stat_emitted (stat_emitted),
    .stat_stall   (stat_stall)
`endif
  );

  // Behavioural integrator: y[n] = x[n] + y[n-1] - x[n-WIN].
  logic [WIDTH-1:0] hist [WIN];
  logic [SUM_W-1:0] model_sum;

  always @(posedge clk) begin
    if (ig_clear) begin
      model_sum <= '0;
      for (int i = 0; i < WIN; i++) hist[i] <= '0;
    end else if (ig_tvalid && ig_oready) begin
      model_sum <= model_sum + SUM_W'(signed'(ig_tdata)) - SUM_W'(signed'(hist[WIN-1]));
      hist[0] <= ig_tdata;
      for (int i = 1; i < WIN; i++) hist[i] <= hist[i-1];
    end
  end
  assign ig_sum = model_sum;

  typedef struct {
    logic             vld;
    logic [WIDTH-1:0] data;
    logic             rdy;
    logic             e_srdy;
    logic             e_mvld;
    logic [SUM_W-1:0] e_mdata;
  } vec_t;

  vec_t vecs[$];
  int   seg_end[4];

  function automatic void add(input bit vld, input int data, input bit rdy,
                              input bit srdy, input bit mvld, input int mdata);
    vec_t v;
    v.vld = vld; v.data = WIDTH'(data); v.rdy = rdy;
    v.e_srdy = srdy; v.e_mvld = mvld; v.e_mdata = SUM_W'(mdata);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance to the next cycle.
  task automatic step(input bit vld, input logic [WIDTH-1:0] data, input bit rdy,
                      input bit e_srdy, input bit e_mvld, input logic [SUM_W-1:0] e_mdata);
    s_tvalid = vld; s_tdata = data; m_tready = rdy;
    @(negedge clk);
    chk("s_tready", 32'(s_tready), 32'(e_srdy));
    chk("m_tvalid", 32'(m_tvalid), 32'(e_mvld));
    if (e_mvld) chk("m_tdata", 32'(m_tdata), 32'(e_mdata));
    chk("ig_clear_run", 32'(ig_clear), 32'd0);
    chk("ig_tvalid", 32'(ig_tvalid), 32'(vld & e_srdy));
    chk("ig_oready", 32'(ig_oready), 32'(e_srdy));
    @(posedge clk); #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      step(vecs[i].vld, vecs[i].data, vecs[i].rdy, vecs[i].e_srdy, vecs[i].e_mvld, vecs[i].e_mdata);
  endtask

  // Enable from IDLE or restart from FILL/RUN; returns at the start of FILL.
  task automatic enter_fill(input bit from_idle, input logic [DEC_W-1:0] decim);
    cfg_decim = decim; s_tvalid = 1'b0; m_tready = 1'b1;
    if (from_idle) cfg_enable = 1'b1;
    else cfg_restart = 1'b1;
    @(posedge clk); #1;
    cfg_restart = 1'b0;
    @(negedge clk);
    chk("flush_ig_clear", 32'(ig_clear), 32'd1);
    chk("flush_s_tready", 32'(s_tready), 32'd0);
    chk("flush_m_tvalid", 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;
`ifdef MOVSUM_SEQ_STATS_EN
    chk("stat_emitted_clr", stat_emitted, 32'd0);
    chk("stat_stall_clr", stat_stall, 32'd0);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ig_clear"},  32'(ig_clear),  32'd1);
    chk({tag, "_s_tready"},  32'(s_tready),  32'd0);
    chk({tag, "_ig_tvalid"}, 32'(ig_tvalid), 32'd0);
    chk({tag, "_ig_oready"}, 32'(ig_oready), 32'd0);
    chk({tag, "_m_tvalid"},  32'(m_tvalid),  32'd0);
    chk({tag, "_m_tdata"},   32'(m_tdata),   32'd0);
  endtask

  initial begin
    // Seg A: decim 1, constant 1 -> 5,5,5 from one cycle after accept 5.
    for (int i = 0; i < 9; i++) add(1, 1, 1, 1, i >= 6, 5);
    seg_end[0] = vecs.size();
    // Seg B: ramp 1..10 -> 15,20,...,40.
    for (int i = 0; i < 13; i++) add(i < 10, (i < 10) ? i + 1 : 0, 1, 1, (i >= 6) && (i <= 11), 5 * i - 15);
    seg_end[1] = vecs.size();
    // Seg C: decim 3, constant 1 -> outputs after accepts 5, 8, 11 only.
    for (int i = 0; i < 14; i++) add(i < 12, 1, 1, 1, (i == 6) || (i == 9) || (i == 12), 5);
    seg_end[2] = vecs.size();
    // Seg D: backpressure for 6 cycles with a capture pending.
    for (int i = 0; i < 6; i++) add(1, i + 1, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) add(1, 7, 0, 0, 1, 15);
    add(1, 7, 1, 1, 1, 15);
    add(1, 8, 1, 1, 1, 20);
    add(1, 9, 1, 1, 1, 25);
    add(0, 0, 1, 1, 1, 30);
    add(0, 0, 1, 1, 1, 35);
    add(0, 0, 1, 1, 0, 0);
    seg_end[3] = vecs.size();

    reset = 1'b1; cfg_enable = 1'b0; cfg_restart = 1'b0; cfg_decim = '0;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    s_tvalid = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    cfg_restart = 1'b1;  // ignored in IDLE
    @(negedge clk);
    chk("idle_s_tready", 32'(s_tready), 32'd0);
    @(posedge clk); #1;
    cfg_restart = 1'b0;
    @(negedge clk);
    chk("idle_after_restart_clear", 32'(ig_clear), 32'd1);
    @(posedge clk); #1;

    enter_fill(1'b1, 8'd1);
    run_rows(0, seg_end[0]);
    enter_fill(1'b0, 8'd0);  // 0 behaves as 1
    run_rows(seg_end[0], seg_end[1]);
    enter_fill(1'b0, 8'd3);
    cfg_decim = 8'd1;        // ignored until next FLUSH
    run_rows(seg_end[1], seg_end[2]);
    enter_fill(1'b0, 8'd1);
    run_rows(seg_end[2], seg_end[3]);

    // Restart while an output is held: old samples must not leak.
    enter_fill(1'b0, 8'd1);
    for (int i = 0; i < 5; i++) step(1, 16'd1, 1, 1, 0, '0);
    step(0, '0, 0, 1, 0, '0);
    cfg_restart = 1'b1;
    step(0, '0, 0, 0, 1, 19'd5);
    cfg_restart = 1'b0;
    @(negedge clk);
    chk("restart_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("restart_ig_clear", 32'(ig_clear), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) step(1, 16'd2, 1, 1, 0, '0);
    step(0, '0, 1, 1, 0, '0);
    step(0, '0, 1, 1, 1, 19'd10);

    // Disable mid-RUN with an output held.
    enter_fill(1'b0, 8'd1);
    for (int i = 0; i < 5; i++) step(1, 16'd3, 1, 1, 0, '0);
    step(0, '0, 0, 1, 0, '0);
    cfg_enable = 1'b0;
    step(0, '0, 0, 0, 1, 19'd15);
    s_tvalid = 1'b1; s_tdata = 16'd7;
    @(negedge clk);
    chk_reset_vals("disable");
    @(posedge clk); #1;

    // Reset mid-RUN with a result in flight.
    enter_fill(1'b1, 8'd1);
    for (int i = 0; i < 6; i++) step(1, 16'd1, 1, 1, 0, '0);
    reset = 1'b1; s_tvalid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_vals("midreset");
    @(posedge clk); #1;
    reset = 1'b0; cfg_enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
